// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// Optional parity checking is enabled with `define UART_RX_PARITY_EN.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } state_t;

   localparam int   DATA_BITS_DEF  = 8;
   localparam int   OVERSAMPLE_DEF = 16;
   localparam logic IDLE_LVL       = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
// RST_VAL sets the level both flops take during reset.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver (8N1) with start-bit validation and break hold.
// Define UART_RX_PARITY_EN to add a parity bit check before the stop bit.
module uart_rx_oversample
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DATA_BITS_DEF,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic                 CLKIN,
   input  logic                 RESET,
   input  logic                 clock_enable,
   input  logic                 rx,
   input  logic                 run,
   output logic [DATA_BITS-1:0] data,
   output logic                 done,
   output logic                 busy,
   output logic                 framing_error,
   output logic                 parity_error
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   state_t               state;
   logic                 rx_s;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bad;

   sync_2ff #(
      .RST_VAL(IDLE_LVL)
   ) u_sync (
      .clk(CLKIN),
      .rst(RESET),
      .d  (rx),
      .q  (rx_s)
   );

   assign busy = (state != IDLE);

`ifndef UART_RX_PARITY_EN
   assign parity_error = 1'b0;
   assign par_bad      = 1'b0;
`endif

   always_ff @(posedge CLKIN) begin
      if (RESET) begin
         state         <= IDLE;
         cnt           <= '0;
         idx           <= '0;
         shreg         <= '0;
         data          <= '0;
         done          <= 1'b0;
         framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad       <= 1'b0;
         parity_error  <= 1'b0;
`endif
      end else begin
         done          <= 1'b0;
         framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_error  <= 1'b0;
`endif
         if (clock_enable) begin
            unique case (state)
               IDLE: begin
                  if (run && rx_s != IDLE_LVL) begin
                     state <= START;
                     cnt   <= '0;
                  end
               end
               // Re-check the line mid start bit to reject glitches
               START: begin
                  if (cnt == CNT_MID) begin
                     cnt   <= '0;
                     idx   <= '0;
                     state <= (rx_s == IDLE_LVL) ? IDLE : DATA;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               DATA: begin
                  if (cnt == CNT_LAST) begin
                     cnt   <= '0;
                     idx   <= idx + 1'b1;
                     shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                     if (idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
`ifdef UART_RX_PARITY_EN
               PARITY: begin
                  if (cnt == CNT_LAST) begin
                     cnt     <= '0;
                     par_bad <= ((^shreg) ^ rx_s) != PARITY_ODD;
                     state   <= STOP;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
`endif
               STOP: begin
                  if (cnt == CNT_LAST) begin
                     cnt <= '0;
`ifdef UART_RX_PARITY_EN
                     parity_error <= par_bad;
`endif
                     if (rx_s == IDLE_LVL) begin
                        state <= IDLE;
                        if (!par_bad) begin
                           data <= shreg;
                           done <= 1'b1;
                        end
                     end else begin
                        framing_error <= 1'b1;
                        state         <= BREAK;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               // Hold off until the line returns high
               BREAK: begin
                  if (rx_s == IDLE_LVL) begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
